ps2_keyboard_ctrl: RTL

- Sequences the byte stream from the PS/2 receiver: Set-2 scancode parser, modifier tracker and event FIFO between the receiver and the CPU/IO bus.
- Consumes single-cycle byte/valid/error pulses and folds E0/F0/E1 prefix sequences into one key event.
- Buffers events in a show-ahead FIFO with a valid/ready pop port.
- Provides resync on timeout or error, plus status counters.

---
 rtl/ps2_kbd_pkg.sv | 71 +++++++
 rtl/ps2_evt_fifo.sv | 83 ++++++++
 rtl/ps2_keyboard_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg
// Shared definitions for the PS/2 Set-2 keyboard controller:
//   - parser state encoding
//   - prefix, discard and overrun byte values
//   - modifier scancodes and MODS bit positions
//   - key event layout {release, extended, code[7:0]} and a packing helper
package ps2_kbd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_E0    = 3'd1,
        ST_F0    = 3'd2,
        ST_E0F0  = 3'd3,
        ST_PAUSE = 3'd4
    } parse_state_e;

    // Prefix bytes
    localparam logic [7:0] PFX_E0 = 8'hE0;
    localparam logic [7:0] PFX_F0 = 8'hF0;
    localparam logic [7:0] PFX_E1 = 8'hE1;

    // Keyboard replies that carry no key information
    localparam logic [7:0] CODE_ACK    = 8'hFA;
    localparam logic [7:0] CODE_BAT_OK = 8'hAA;
    localparam logic [7:0] CODE_ECHO   = 8'hEE;
    localparam logic [7:0] CODE_RESEND = 8'hFE;

    // Keyboard-side buffer overrun markers
    localparam logic [7:0] CODE_OVR_00 = 8'h00;
    localparam logic [7:0] CODE_OVR_FF = 8'hFF;

    // Bytes to skip after E1 before the pause key event is emitted
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // Modifier scancodes (rctrl/ralt are the E0-prefixed forms of ctrl/alt)
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;

    // MODS bit positions: {ralt, lalt, rctrl, lctrl, rshift, lshift}
    localparam int MOD_W      = 6;
    localparam int MOD_LSHIFT = 0;
    localparam int MOD_RSHIFT = 1;
    localparam int MOD_LCTRL  = 2;
    localparam int MOD_RCTRL  = 3;
    localparam int MOD_LALT   = 4;
    localparam int MOD_RALT   = 5;

    // Event layout
    localparam int EVT_W        = 10;
    localparam int EVT_REL_BIT  = 9;
    localparam int EVT_EXT_BIT  = 8;
    localparam int EVT_CODE_LSB = 0;

    function automatic logic [EVT_W-1:0] make_evt(input logic rel,
                                                  input logic ext,
                                                  input logic [7:0] code);
        return {rel, ext, code};
    endfunction

    function automatic logic is_discard(input logic [7:0] b);
        return (b == CODE_ACK) || (b == CODE_BAT_OK) ||
               (b == CODE_ECHO) || (b == CODE_RESEND);
    endfunction

    function automatic logic is_overrun(input logic [7:0] b);
        return (b == CODE_OVR_00) || (b == CODE_OVR_FF);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo
// Show-ahead synchronous FIFO with a registered head output.
//   clk        system clock
//   rst        synchronous, active-high reset
//   push       write push_data (accepted if not full, or if a pop is accepted
//              in the same cycle)
//   push_data  entry to write
//   pop        remove the head (ignored when empty)
//   head       current head entry, registered; zero when empty
//   empty      no entries stored
//   full       DEPTH entries stored
module ps2_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             pop_ok;
    logic             push_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign head  = head_q;

    // NOTE: every signal assigned in always_comb gets a default up front, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        head_d   = mem_q[rd_ptr_d];
        // The slot becoming the head may be the one written this cycle
        // (empty FIFO, or a single entry being popped while pushing).
        if (count_d == '0) begin
            head_d = '0;
        end else if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; contents are only
    // observable through head_q, which is reset and gated by the count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ps2_keyboard_ctrl.sv
// ps2_keyboard_ctrl
// Set-2 scancode parser, modifier tracker and event FIFO between a PS/2
// byte receiver and the CPU/IO bus.
//   CLK        system clock
//   RESET      synchronous, active-high reset
//   RX_DATA    received byte, valid while RX_VALID
//   RX_VALID   one-cycle pulse, byte received with good parity
//   RX_ERROR   one-cycle pulse, parity or stop-bit error
//   EVT_DATA   FIFO head {release, extended, code[7:0]}
//   EVT_VALID  FIFO non-empty
//   EVT_READY  pops the head when EVT_VALID is high
//   MODS       {ralt, lalt, rctrl, lctrl, rshift, lshift}, 1 = held
//   OVERFLOW   sticky, an event was dropped on a full FIFO
//   ERR_COUNT  saturating error count
//   CLEAR      clears OVERFLOW and ERR_COUNT
module ps2_keyboard_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [7:0]       RX_DATA,
    input  logic             RX_VALID,
    input  logic             RX_ERROR,
    output logic [EVT_W-1:0] EVT_DATA,
    output logic             EVT_VALID,
    input  logic             EVT_READY,
    output logic [MOD_W-1:0] MODS,
    output logic             OVERFLOW,
    output logic [7:0]       ERR_COUNT,
    input  logic             CLEAR
);

    localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    parse_state_e     state_q, state_d;
    logic [2:0]       skip_q, skip_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             push_q, push_d;
    logic [EVT_W-1:0] push_data_q, push_data_d;
    logic [MOD_W-1:0] mods_q, mods_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       err_q, err_d;

    logic             err_evt;
    logic             fifo_empty;
    logic             fifo_full;
    logic             evt_rel;
    logic             evt_ext;
    logic [7:0]       evt_code;

    // Parser: folds prefixes into one event; RX_ERROR outranks RX_VALID and
    // RX_VALID outranks timeout expiry.
    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        tmo_d       = tmo_q;
        push_d      = 1'b0;
        push_data_d = '0;
        err_evt     = 1'b0;

        if (RX_ERROR) begin
            state_d = ST_IDLE;
            skip_d  = '0;
            tmo_d   = '0;
            err_evt = 1'b1;
        end else if (RX_VALID) begin
            tmo_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (RX_DATA == PFX_E0) begin
                        state_d = ST_E0;
                    end else if (RX_DATA == PFX_F0) begin
                        state_d = ST_F0;
                    end else if (RX_DATA == PFX_E1) begin
                        state_d = ST_PAUSE;
                        skip_d  = PAUSE_SKIP;
                    end else if (is_overrun(RX_DATA)) begin
                        err_evt = 1'b1;
                    end else if (!is_discard(RX_DATA)) begin
                        push_d      = 1'b1;
                        push_data_d = make_evt(1'b0, 1'b0, RX_DATA);
                    end
                end
                ST_E0: begin
                    if (RX_DATA == PFX_F0) begin
                        state_d = ST_E0F0;
                    end else begin
                        state_d     = ST_IDLE;
                        push_d      = 1'b1;
                        push_data_d = make_evt(1'b0, 1'b1, RX_DATA);
                    end
                end
                ST_F0: begin
                    state_d     = ST_IDLE;
                    push_d      = 1'b1;
                    push_data_d = make_evt(1'b1, 1'b0, RX_DATA);
                end
                ST_E0F0: begin
                    state_d     = ST_IDLE;
                    push_d      = 1'b1;
                    push_data_d = make_evt(1'b1, 1'b1, RX_DATA);
                end
                ST_PAUSE: begin
                    // Pause sends a fixed tail; only its length matters.
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        state_d     = ST_IDLE;
                        push_d      = 1'b1;
                        push_data_d = make_evt(1'b0, 1'b1, PFX_E1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = ST_IDLE;
                skip_d  = '0;
                tmo_d   = '0;
                err_evt = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    // Modifiers follow the event being pushed this cycle, accepted or not.
    assign evt_rel  = push_data_q[EVT_REL_BIT];
    assign evt_ext  = push_data_q[EVT_EXT_BIT];
    assign evt_code = push_data_q[EVT_CODE_LSB +: 8];

    always_comb begin
        mods_d = mods_q;
        if (push_q) begin
            if (!evt_ext && evt_code == SC_LSHIFT) mods_d[MOD_LSHIFT] = ~evt_rel;
            if (!evt_ext && evt_code == SC_RSHIFT) mods_d[MOD_RSHIFT] = ~evt_rel;
            if (!evt_ext && evt_code == SC_CTRL)   mods_d[MOD_LCTRL]  = ~evt_rel;
            if ( evt_ext && evt_code == SC_CTRL)   mods_d[MOD_RCTRL]  = ~evt_rel;
            if (!evt_ext && evt_code == SC_ALT)    mods_d[MOD_LALT]   = ~evt_rel;
            if ( evt_ext && evt_code == SC_ALT)    mods_d[MOD_RALT]   = ~evt_rel;
        end

        // A full FIFO is never empty, so EVT_READY alone means a pop.
        ovf_d = CLEAR ? 1'b0 : (ovf_q | (push_q & fifo_full & ~EVT_READY));

        err_d = err_q;
        if (CLEAR) begin
            err_d = '0;
        end else if (err_evt && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            skip_q      <= '0;
            tmo_q       <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            mods_q      <= '0;
            ovf_q       <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            tmo_q       <= tmo_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            mods_q      <= mods_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .push      (push_q),
        .push_data (push_data_q),
        .pop       (EVT_READY),
        .head      (EVT_DATA),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign EVT_VALID = ~fifo_empty;
    assign MODS      = mods_q;
    assign OVERFLOW  = ovf_q;
    assign ERR_COUNT = err_q;

endmodule
